// File: rtl/hazard_controller_pkg.sv
// Shared defines for the hazard controller and the forwarding block: opcodes, forward codes,
// pipeline tracker entry type and decode helpers.
package hazard_controller_pkg;

  localparam int unsigned OpWidth  = 7;
  localparam int unsigned RegWidth = 5;
  localparam int unsigned FwdWidth = 3;

  localparam logic [OpWidth-1:0] OpcLoad   = 7'b0000011;
  localparam logic [OpWidth-1:0] OpcStore  = 7'b0100011;
  localparam logic [OpWidth-1:0] OpcBranch = 7'b1100011;
  localparam logic [OpWidth-1:0] OpcJal    = 7'b1101111;
  localparam logic [OpWidth-1:0] OpcJalr   = 7'b1100111;
  localparam logic [OpWidth-1:0] OpcLui    = 7'b0110111;
  localparam logic [OpWidth-1:0] OpcAuipc  = 7'b0010111;
  localparam logic [OpWidth-1:0] OpcOp     = 7'b0110011;
  localparam logic [OpWidth-1:0] OpcOpImm  = 7'b0010011;

  localparam logic [FwdWidth-1:0] FwdNone   = 3'd0;
  localparam logic [FwdWidth-1:0] FwdExRs1  = 3'd1;
  localparam logic [FwdWidth-1:0] FwdExRs2  = 3'd2;
  localparam logic [FwdWidth-1:0] FwdMemRs1 = 3'd3;
  localparam logic [FwdWidth-1:0] FwdMemRs2 = 3'd4;

  typedef struct packed {
    logic                valid;
    logic [RegWidth-1:0] rd;
    logic                wr;
    logic [OpWidth-1:0]  op;
  } tracker_entry_t;

  typedef enum logic [1:0] {StRun, StLoadStall, StFlush} hc_state_e;

  function automatic logic uses_rs1(input logic [OpWidth-1:0] op);
    return !((op == OpcLui) || (op == OpcAuipc) || (op == OpcJal));
  endfunction

  function automatic logic uses_rs2(input logic [OpWidth-1:0] op);
    return (op == OpcOp) || (op == OpcStore) || (op == OpcBranch);
  endfunction

  // Invalid decode slots become a clean bubble so stale fields never match.
  function automatic tracker_entry_t decode_entry(input logic                valid,
                                                  input logic [OpWidth-1:0]  op,
                                                  input logic [RegWidth-1:0] rd);
    tracker_entry_t e;
    e = '0;
    if (valid) begin
      e.valid = 1'b1;
      e.rd    = rd;
      e.op    = op;
      e.wr    = (rd != '0) && (op != OpcStore) && (op != OpcBranch);
    end
    return e;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side bundle between the pipeline (master) and the hazard controller (slave).
interface hazard_controller_if;
  import hazard_controller_pkg::*;

  logic                id_valid;
  logic [OpWidth-1:0]  id_op;
  logic [RegWidth-1:0] id_rs1;
  logic [RegWidth-1:0] id_rs2;
  logic [RegWidth-1:0] id_rd;
  logic                branch_taken;
  logic                stall;
  logic                flush;
  logic                is_hazard1;
  logic                is_hazard2;
  logic [FwdWidth-1:0] hazard_reg1;
  logic [FwdWidth-1:0] hazard_reg2;
  logic [OpWidth-1:0]  mem_op;

  modport master (
    output id_valid, id_op, id_rs1, id_rs2, id_rd, branch_taken,
    input  stall, flush, is_hazard1, is_hazard2, hazard_reg1, hazard_reg2, mem_op
  );

  modport slave (
    input  id_valid, id_op, id_rs1, id_rs2, id_rd, branch_taken,
    output stall, flush, is_hazard1, is_hazard2, hazard_reg1, hazard_reg2, mem_op
  );

endinterface

// File: rtl/hazard_tracker_stage.sv
// One pipeline-stage tracker entry; a bubble request loads an empty entry.
module hazard_tracker_stage
  import hazard_controller_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           bubble,
  input  tracker_entry_t entry_in,
  output tracker_entry_t entry
);

  tracker_entry_t entry_q;

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_in;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_controller.sv
// Data-hazard detection for a 5-stage pipeline: EX/MEM producer compare, load-use stall and
// branch flush control.
module hazard_controller
  import hazard_controller_pkg::*;
(
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave bus
);

  tracker_entry_t id_entry;
  tracker_entry_t ex_entry;
  tracker_entry_t mem_entry;

  hc_state_e state_q;
  hc_state_e state_d;

  logic rs1_used;
  logic rs2_used;
  logic ex_rs1_hit;
  logic ex_rs2_hit;
  logic mem_rs1_hit;
  logic mem_rs2_hit;
  logic load_use;
  logic stall_now;
  logic flush_now;

  always_comb begin
    id_entry = decode_entry(bus.id_valid, bus.id_op, bus.id_rd);

    // x0 is filtered here so a zero rd never matches even if wr were set.
    rs1_used = bus.id_valid && uses_rs1(bus.id_op) && (bus.id_rs1 != '0);
    rs2_used = bus.id_valid && uses_rs2(bus.id_op) && (bus.id_rs2 != '0);

    ex_rs1_hit  = ex_entry.wr && rs1_used && (ex_entry.rd == bus.id_rs1);
    ex_rs2_hit  = ex_entry.wr && rs2_used && (ex_entry.rd == bus.id_rs2);
    mem_rs1_hit = mem_entry.wr && rs1_used && (mem_entry.rd == bus.id_rs1);
    mem_rs2_hit = mem_entry.wr && rs2_used && (mem_entry.rd == bus.id_rs2);

    load_use = ex_entry.valid && (ex_entry.op == OpcLoad) && (ex_rs1_hit || ex_rs2_hit);

    // Redirect wins over a load-use stall; the flush already kills the consumer.
    state_d = StRun;
    if (bus.branch_taken) begin
      state_d = StFlush;
    end else if (load_use && (state_q != StLoadStall)) begin
      state_d = StLoadStall;
    end

    stall_now = (state_d == StLoadStall);
    flush_now = (state_d == StFlush);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  hazard_tracker_stage u_ex_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble   (stall_now || flush_now),
    .entry_in (id_entry),
    .entry    (ex_entry)
  );

  hazard_tracker_stage u_mem_stage (
    .clk      (clk),
    .reset    (reset),
    .bubble   (1'b0),
    .entry_in (ex_entry),
    .entry    (mem_entry)
  );

  always_comb begin
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.is_hazard1  = 1'b0;
    bus.is_hazard2  = 1'b0;
    bus.hazard_reg1 = FwdNone;
    bus.hazard_reg2 = FwdNone;
    bus.mem_op      = '0;
    if (!reset) begin
      bus.stall  = stall_now;
      bus.flush  = flush_now;
      bus.mem_op = mem_entry.valid ? mem_entry.op : '0;
      if (!stall_now && !flush_now) begin
        bus.is_hazard1  = ex_rs1_hit || ex_rs2_hit;
        bus.hazard_reg1 = ex_rs1_hit ? FwdExRs1 : (ex_rs2_hit ? FwdExRs2 : FwdNone);
        bus.is_hazard2  = mem_rs1_hit || mem_rs2_hit;
        bus.hazard_reg2 = mem_rs1_hit ? FwdMemRs1 : (mem_rs2_hit ? FwdMemRs2 : FwdNone);
      end
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding codes, load-use stall, flush and reset.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_controller_if hif ();

  hazard_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  // Output word: {stall, flush, is_hazard1, hazard_reg1, is_hazard2, hazard_reg2, mem_op}
  function automatic logic [16:0] outs();
    return {hif.stall, hif.flush, hif.is_hazard1, hif.hazard_reg1,
            hif.is_hazard2, hif.hazard_reg2, hif.mem_op};
  endfunction

  function automatic logic [16:0] expv(input logic s, input logic f, input logic h1,
                                       input logic [2:0] c1, input logic h2,
                                       input logic [2:0] c2, input logic [6:0] m);
    return {s, f, h1, c1, h2, c2, m};
  endfunction

  task automatic set_id(input logic v, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    hif.id_valid = v;
    hif.id_op    = op;
    hif.id_rs1   = rs1;
    hif.id_rs2   = rs2;
    hif.id_rd    = rd;
  endtask

  task automatic idle();
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    hif.branch_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [16:0] want;
    reset = 1'b1;
    idle();
    set_id(1'b1, OpcOp, 5'd1, 5'd2, 5'd5);
    tick();
    tick();
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", outs(), want);
    end
    reset = 1'b0;
    set_id(1'b1, OpcOp, 5'd5, 5'd5, 5'd6);
    settle();
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL reset_first_run: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_ex_forward();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcOp, 5'd1, 5'd2, 5'd5);
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL ex_first: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd5, 5'd7, 5'd6);
    settle();
    want = expv(0, 0, 1, FwdExRs1, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL ex_rs1: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd1, 5'd6, 5'd9);
    settle();
    want = expv(0, 0, 1, FwdExRs2, 0, FwdNone, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL ex_rs2: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd6, 5'd9, 5'd10);
    settle();
    want = expv(0, 0, 1, FwdExRs2, 1, FwdMemRs1, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL ex_mem_mix: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd10, 5'd10, 5'd11);
    settle();
    want = expv(0, 0, 1, FwdExRs1, 0, FwdNone, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL ex_rs1_priority: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcOp, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OpcOp, 5'd5, 5'd1, 5'd5);
    settle();
    want = expv(0, 0, 1, FwdExRs1, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL b2b_same_rd: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd5, 5'd0, 5'd7);
    settle();
    want = expv(0, 0, 1, FwdExRs1, 1, FwdMemRs1, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL b2b_ex_and_mem: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_load_use();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcLoad, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OpcOp, 5'd1, 5'd5, 5'd6);
    settle();
    want = expv(1, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL load_stall: got %h expected %h", outs(), want);
    end
    tick();
    settle();
    want = expv(0, 0, 0, FwdNone, 1, FwdMemRs2, OpcLoad);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL load_after_stall: got %h expected %h", outs(), want);
    end
    tick();
    idle();
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL load_bubble_in_mem: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_mem_forward();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcOp, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OpcOpImm, 5'd0, 5'd0, 5'd0);
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL nop_no_hazard: got %h expected %h", outs(), want);
    end
    tick();
    // rd field of a store carries immediate bits; 5 here must not look like a write.
    set_id(1'b1, OpcStore, 5'd2, 5'd5, 5'd5);
    settle();
    want = expv(0, 0, 0, FwdNone, 1, FwdMemRs2, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL mem_rs2_store: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcOp, 5'd5, 5'd0, 5'd7);
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, OpcOpImm);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL store_no_write: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_x0();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcOp, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OpcOp, 5'd0, 5'd0, 5'd3);
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL x0_no_hazard: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcLui, 5'd3, 5'd3, 5'd4);
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL lui_no_sources: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_branch_priority();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcLoad, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OpcOp, 5'd1, 5'd5, 5'd6);
    hif.branch_taken = 1'b1;
    settle();
    want = expv(0, 1, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL branch_over_stall: got %h expected %h", outs(), want);
    end
    tick();
    idle();
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, OpcLoad);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL after_flush_run: got %h expected %h", outs(), want);
    end
    tick();
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL flush_bubble: got %h expected %h", outs(), want);
    end
  endtask

  task automatic test_reset_in_stall();
    logic [16:0] want;
    drain();
    set_id(1'b1, OpcLoad, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OpcOp, 5'd1, 5'd5, 5'd6);
    settle();
    want = expv(1, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL pre_reset_stall: got %h expected %h", outs(), want);
    end
    reset = 1'b1;
    settle();
    want = expv(0, 0, 0, FwdNone, 0, FwdNone, 7'd0);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h expected %h", outs(), want);
    end
    tick();
    settle();
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", outs(), want);
    end
    reset = 1'b0;
    settle();
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL post_reset_run: got %h expected %h", outs(), want);
    end
    tick();
    set_id(1'b1, OpcLoad, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OpcOp, 5'd5, 5'd0, 5'd6);
    settle();
    want = expv(1, 0, 0, FwdNone, 0, FwdNone, OpcOp);
    checks++;
    if (outs() !== want) begin
      errors++;
      $display("FAIL stall_after_reset: got %h expected %h", outs(), want);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_ex_forward();
    test_back_to_back();
    test_load_use();
    test_mem_forward();
    test_x0();
    test_branch_priority();
    test_reset_in_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
